// File: rtl/smac_pkg.sv
// rtl/smac_pkg.sv - shared types, mode geometry and saturation helpers for the SIMD MAC slice
// Contents: precision_e lane-width enum, NMODES, lane_w/n_lanes geometry, sat_max/sat_min bounds.
package smac_pkg;

    localparam int NMODES         = 4;
    localparam int DATA_W_DEF     = 64;
    localparam int LANE_MIN_W_DEF = 8;
    localparam int SAT_W          = 64;

    typedef enum logic [1:0] {
        PREC_8  = 2'd0,
        PREC_16 = 2'd1,
        PREC_32 = 2'd2,
        PREC_64 = 2'd3
    } precision_e;

    function automatic int lane_w(input int m, input int min_w = LANE_MIN_W_DEF);
        return min_w << m;
    endfunction

    function automatic int n_lanes(input int m, input int data_w = DATA_W_DEF,
                                   input int min_w = LANE_MIN_W_DEF);
        return data_w / lane_w(m, min_w);
    endfunction

    // Bounds are returned zero-extended to SAT_W; callers truncate to their lane width.
    function automatic logic [SAT_W-1:0] sat_max(input int w);
        return (SAT_W'(1) << (w - 1)) - SAT_W'(1);
    endfunction

    function automatic logic [SAT_W-1:0] sat_min(input int w);
        return SAT_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/smac_simd_if.sv
// rtl/smac_simd_if.sv - beat-in / result-out handshake bundle of the SIMD MAC slice
// Signals: in_valid/in_ready, mode, active_chain, data_input, weight, res_mac_p (beat side);
//   out_valid/out_ready, res_mac_n, out_ovf (result side).
// Modports: slave = the MAC slice, master = feeder plus partial-sum consumer.
interface smac_simd_if #(
    parameter int DATA_W     = 64,
    parameter int LANE_MIN_W = 8
);
    localparam int NMIN = DATA_W / LANE_MIN_W;

    logic              in_valid;
    logic              in_ready;
    logic [1:0]        mode;
    logic              active_chain;
    logic [DATA_W-1:0] data_input;
    logic [DATA_W-1:0] weight;
    logic [DATA_W-1:0] res_mac_p;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] res_mac_n;
    logic [NMIN-1:0]   out_ovf;

    modport slave (
        input  in_valid, mode, active_chain, data_input, weight, res_mac_p, out_ready,
        output in_ready, out_valid, res_mac_n, out_ovf
    );

    modport master (
        output in_valid, mode, active_chain, data_input, weight, res_mac_p, out_ready,
        input  in_ready, out_valid, res_mac_n, out_ovf
    );
endinterface

// File: rtl/smac_lane.sv
// rtl/smac_lane.sv - one signed lane: a*b + p (+ chained prefix of lower products), overflow, wrap/clamp
// Ports: a, b, p (LANE_W signed lane operands), chain_en, pref_in (sum of lower-lane products),
//   pref_out (pref_in + own product), res (LANE_W result), ovf (sum does not fit signed LANE_W).
// Build option: SMAC_SATURATE_EN clamps overflowing results to the signed lane bounds.
module smac_lane
    import smac_pkg::*;
#(
    parameter int LANE_W = 8,
    parameter int SUM_W  = 2 * LANE_W + 1
) (
    input  logic [LANE_W-1:0]       a,
    input  logic [LANE_W-1:0]       b,
    input  logic [LANE_W-1:0]       p,
    input  logic                    chain_en,
    input  logic signed [SUM_W-1:0] pref_in,
    output logic signed [SUM_W-1:0] pref_out,
    output logic [LANE_W-1:0]       res,
    output logic                    ovf
);
    localparam int PW = 2 * LANE_W;

    logic signed [PW-1:0]    a_x, b_x, prod;
    logic signed [SUM_W-1:0] prod_x, p_x, sum;
    logic [SUM_W-LANE_W:0]   top_bits;

    // Operands sign-extended to 2W so the 2W-bit product is the exact signed product.
    assign a_x    = {{LANE_W{a[LANE_W-1]}}, a};
    assign b_x    = {{LANE_W{b[LANE_W-1]}}, b};
    assign prod   = a_x * b_x;
    assign prod_x = {{(SUM_W-PW){prod[PW-1]}}, prod};
    assign p_x    = {{(SUM_W-LANE_W){p[LANE_W-1]}}, p};

    assign pref_out = pref_in + prod_x;
    assign sum      = p_x + prod_x + (chain_en ? pref_in : '0);

    // Fits in signed LANE_W only if every bit from the lane sign bit upward agrees.
    assign top_bits = sum[SUM_W-1:LANE_W-1];
    assign ovf      = !((&top_bits) || !(|top_bits));

`ifdef SMAC_SATURATE_EN
    always_comb begin
        res = sum[LANE_W-1:0];
        if (ovf) begin
            res = sum[SUM_W-1] ? LANE_W'(sat_min(LANE_W)) : LANE_W'(sat_max(LANE_W));
        end
    end
`else
    assign res = sum[LANE_W-1:0];
`endif

endmodule

// File: rtl/smac_simd.sv
// rtl/smac_simd.sv - packed-SIMD multiply-accumulate slice, per-beat lane width, two-stage valid/ready pipe
// Ports: clk, sclr (synchronous active-high reset, wins over ce), ce (global enable, 0 freezes state),
//   bus (smac_simd_if.slave): beat in_valid/in_ready/mode/active_chain/data_input/weight/res_mac_p,
//   result out_valid/out_ready/res_mac_n/out_ovf.
// Build option: SMAC_SATURATE_EN (lane clamp on overflow, inside smac_lane).
module smac_simd #(
    parameter int DATA_W     = 64,
    parameter int LANE_MIN_W = 8,
    parameter int NMODES     = smac_pkg::NMODES
) (
    input  logic       clk,
    input  logic       sclr,
    input  logic       ce,
    smac_simd_if.slave bus
);
    import smac_pkg::*;

    localparam int NMIN = DATA_W / LANE_MIN_W;

    logic              s1_valid, s2_valid;
    precision_e        s1_mode;
    logic              s1_chain;
    logic [DATA_W-1:0] s1_a, s1_b, s1_p;
    logic [DATA_W-1:0] res_q;
    logic [NMIN-1:0]   ovf_q;
    logic              s2_free, accept;
    logic [DATA_W-1:0] mode_res [NMODES];
    logic [NMIN-1:0]   mode_ovf [NMODES];
    logic [DATA_W-1:0] s2_res_d;
    logic [NMIN-1:0]   s2_ovf_d;

    // S2 can take a new beat when it is empty or its result leaves this cycle.
    assign s2_free       = !s2_valid || bus.out_ready;
    assign bus.in_ready  = ce && (!s1_valid || s2_free);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = s2_valid;
    assign bus.res_mac_n = res_q;
    assign bus.out_ovf   = ovf_q;

    // Every lane geometry is built in parallel; the beat's own mode picks one below.
    for (genvar m = 0; m < NMODES; m++) begin : g_mode
        localparam int LW = lane_w(m, LANE_MIN_W);
        localparam int NL = n_lanes(m, DATA_W, LANE_MIN_W);
        localparam int RW = LW / LANE_MIN_W;
        localparam int SW = 2 * LW + $clog2(NL) + 1;

        logic signed [SW-1:0] pref [NL+1];
        logic [DATA_W-1:0]    r;
        logic [NMIN-1:0]      o;

        assign pref[0] = '0;

        for (genvar k = 0; k < NL; k++) begin : g_lane
            logic lane_ovf;

            smac_lane #(.LANE_W(LW), .SUM_W(SW)) u_lane (
                .a        (s1_a[k*LW +: LW]),
                .b        (s1_b[k*LW +: LW]),
                .p        (s1_p[k*LW +: LW]),
                .chain_en (s1_chain),
                .pref_in  (pref[k]),
                .pref_out (pref[k+1]),
                .res      (r[k*LW +: LW]),
                .ovf      (lane_ovf)
            );

            assign o[k*RW +: RW] = {RW{lane_ovf}};
        end

        assign mode_res[m] = r;
        assign mode_ovf[m] = o;
    end

    // Unsupported modes still flow through the pipe but report zero with every lane flagged.
    always_comb begin
        s2_res_d = '0;
        s2_ovf_d = '1;
        if (int'(s1_mode) < NMODES) begin
            s2_res_d = mode_res[s1_mode];
            s2_ovf_d = mode_ovf[s1_mode];
        end
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            res_q    <= '0;
            ovf_q    <= '0;
        end else if (ce) begin
            if (s2_free) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    res_q <= s2_res_d;
                    ovf_q <= s2_ovf_d;
                end
            end
            if (accept) begin
                s1_valid <= 1'b1;
            end else if (s2_free) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Operand capture needs no reset: s1_valid qualifies everything downstream.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_mode  <= precision_e'(bus.mode);
            s1_chain <= bus.active_chain;
            s1_a     <= bus.data_input;
            s1_b     <= bus.weight;
            s1_p     <= bus.res_mac_p;
        end
    end

endmodule

// File: tb/tb_smac_simd.sv
// tb/tb_smac_simd.sv - self-checking bench for smac_simd: directed cases, stall/reset/enable, random beats
module tb_smac_simd;

    typedef struct packed {
        logic [63:0] res;
        logic [7:0]  ovf;
    } exp_t;

    logic clk = 1'b0;
    logic sclr;
    logic ce;

    always #5 clk = ~clk;

    smac_simd_if #(.DATA_W(64), .LANE_MIN_W(8)) bus ();

    smac_simd #(.DATA_W(64), .LANE_MIN_W(8), .NMODES(4)) dut (
        .clk  (clk),
        .sclr (sclr),
        .ce   (ce),
        .bus  (bus.slave)
    );

    exp_t        exp_q [$];
    int          checks = 0;
    int          passed = 0;
    logic        seen_in_ready;
    logic        seen_accept;
    logic        hold_pending = 1'b0;
    logic [63:0] hold_res;
    logic [7:0]  hold_ovf;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Signed value of lane k (width w) of a packed word.
    function automatic logic signed [159:0] sx(input logic [63:0] v, input int k, input int w);
        logic [63:0]            t;
        logic signed [159:0]    u;
        t = v >> (k * w);
        if (w < 64) t = t & ((64'd1 << w) - 64'd1);
        u = $signed({96'd0, t});
        if (t[w-1]) u = u - (160'sd1 <<< w);
        return u;
    endfunction

    // Reference: plain integer arithmetic per lane, prefix of products when chained.
    function automatic void ref_model(input int m, input logic ch, input logic [63:0] a,
                                      input logic [63:0] b, input logic [63:0] p,
                                      output logic [63:0] r, output logic [7:0] o);
        int                  w, nl;
        logic signed [159:0] acc, full, prod, lim;
        logic [63:0]         mask, lane;
        logic                ovf;
        r   = '0;
        o   = '0;
        acc = '0;
        if (m >= 4) begin
            o = '1;
            return;
        end
        w    = 8 << m;
        nl   = 64 / w;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        lim  = 160'sd1 <<< (w - 1);
        for (int k = 0; k < nl; k++) begin
            prod = sx(a, k, w) * sx(b, k, w);
            full = sx(p, k, w) + prod + (ch ? acc : 160'sd0);
            acc  = acc + prod;
            ovf  = (full >= lim) || (full < -lim);
            lane = 64'(full) & mask;
`ifdef SMAC_SATURATE_EN
            if (ovf) lane = (full < 0) ? (64'd1 << (w - 1)) : (mask >> 1);
`endif
            r = r | (lane << (k * w));
            if (ovf) o = o | (8'((16'd1 << (w / 8)) - 16'd1) << (k * (w / 8)));
        end
    endfunction

    // One clock: sample handshakes mid-cycle, update scoreboard, then move just past the edge.
    task automatic step();
        exp_t        e;
        logic [63:0] r;
        logic [7:0]  o;
        @(negedge clk);
        seen_in_ready = bus.in_ready;
        seen_accept   = 1'b0;
        if (hold_pending) begin
            chk("hold_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_res", bus.res_mac_n, hold_res);
            chk("hold_ovf", 64'(bus.out_ovf), 64'(hold_ovf));
        end
        hold_pending = !sclr && bus.out_valid && (!bus.out_ready || !ce);
        hold_res     = bus.res_mac_n;
        hold_ovf     = bus.out_ovf;
        if (sclr) begin
            exp_q.delete();
        end else if (ce) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 64'(bus.out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_res", bus.res_mac_n, e.res);
                    chk("sb_ovf", 64'(bus.out_ovf), 64'(e.ovf));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                ref_model(int'(bus.mode), bus.active_chain, bus.data_input, bus.weight,
                          bus.res_mac_p, r, o);
                e.res = r;
                e.ovf = o;
                exp_q.push_back(e);
                seen_accept = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] m, input logic ch, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] p);
        bus.in_valid     = 1'b1;
        bus.mode         = m;
        bus.active_chain = ch;
        bus.data_input   = a;
        bus.weight       = b;
        bus.res_mac_p    = p;
    endtask

    function automatic logic [63:0] rnd64();
        logic [63:0] v;
        v = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) v = v & 64'h0707_0707_0707_0707;
        return v;
    endfunction

    task automatic directed(input string tag, input logic [1:0] m, input logic ch,
                            input logic [63:0] a, input logic [63:0] b, input logic [63:0] p,
                            input logic [63:0] exp_r, input logic [7:0] exp_o);
        bus.out_ready = 1'b1;
        drive(m, ch, a, b, p);
        step();
        chk({tag, "_acc"}, 64'(seen_accept), 64'd1);
        bus.in_valid = 1'b0;
        chk({tag, "_lat1"}, 64'(bus.out_valid), 64'd0);
        step();
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_res"}, bus.res_mac_n, exp_r);
        chk({tag, "_ovf"}, 64'(bus.out_ovf), 64'(exp_o));
        step();
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        ce            = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
        step();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [63:0] a, b, p, snap_res;
        logic [7:0]  snap_ovf;
        logic [1:0]  m;
        logic        ch;
        int          sent, cyc;

        // Reset with ce low: reset must still win.
        sclr = 1'b1;
        ce   = 1'b0;
        drive(2'd0, 1'b0, '0, '0, '0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        sclr = 1'b0;
        ce   = 1'b1;
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_res", bus.res_mac_n, 64'd0);
        chk("rst_ovf", 64'(bus.out_ovf), 64'd0);

        directed("t1", 2'd0, 1'b0, 64'h0202_0202_0202_0202, 64'h0202_0202_0202_0202,
                 64'h0101_0101_0101_0101, 64'h0505_0505_0505_0505, 8'h00);
        directed("t2", 2'd0, 1'b1, 64'h0101_0101_0101_0101, 64'h0101_0101_0101_0101,
                 64'd0, 64'h0807_0605_0403_0201, 8'h00);
`ifdef SMAC_SATURATE_EN
        directed("t3", 2'd1, 1'b0, 64'h7FFF, 64'd2, 64'd0, 64'h7FFF, 8'h03);
`else
        directed("t3", 2'd1, 1'b0, 64'h7FFF, 64'd2, 64'd0, 64'hFFFE, 8'h03);
`endif
        directed("t4", 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'd10,
                 64'hFFFF_FFFF_FFFF_FFFB, 8'h00);

        // Four back-to-back beats of modes 0..3 into a sink that stalls for 3 cycles.
        sent = 0;
        cyc  = 0;
        a = rnd64(); b = rnd64(); p = rnd64(); ch = 1'($urandom);
        while (sent < 4 && cyc < 40) begin
            bus.out_ready = (cyc >= 3);
            drive(2'(sent), ch, a, b, p);
            step();
            if (cyc == 1) chk("stall_rdy1", 64'(seen_in_ready), 64'd1);
            if (cyc == 2) chk("stall_rdy2", 64'(seen_in_ready), 64'd0);
            if (seen_accept) begin
                sent++;
                a = rnd64(); b = rnd64(); p = rnd64(); ch = 1'($urandom);
            end
            cyc++;
        end
        chk("stall_sent", 64'(sent), 64'd4);
        drain();

        // Reset with two beats in flight: both must vanish.
        bus.out_ready = 1'b0;
        drive(2'd0, 1'b0, rnd64(), rnd64(), rnd64());
        step();
        drive(2'd2, 1'b1, rnd64(), rnd64(), rnd64());
        step();
        bus.in_valid = 1'b0;
        sclr = 1'b1;
        step();
        sclr = 1'b0;
        bus.out_ready = 1'b1;
        chk("sclr_valid", 64'(bus.out_valid), 64'd0);
        chk("sclr_res", bus.res_mac_n, 64'd0);
        chk("sclr_ovf", 64'(bus.out_ovf), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("sclr_quiet", 64'(bus.out_valid), 64'd0);
        end

        // ce low for 5 cycles with one result showing and one beat behind it.
        drive(2'd1, 1'b0, rnd64(), rnd64(), rnd64());
        step();
        drive(2'd3, 1'b0, rnd64(), rnd64(), rnd64());
        step();
        drive(2'd0, 1'b1, rnd64(), rnd64(), rnd64());
        ce       = 1'b0;
        snap_res = bus.res_mac_n;
        snap_ovf = bus.out_ovf;
        chk("ce_pre_valid", 64'(bus.out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("ce_in_ready", 64'(seen_in_ready), 64'd0);
            chk("ce_valid", 64'(bus.out_valid), 64'd1);
            chk("ce_res", bus.res_mac_n, snap_res);
            chk("ce_ovf", 64'(bus.out_ovf), 64'(snap_ovf));
        end
        ce = 1'b1;
        step();
        chk("ce_resume_acc", 64'(seen_accept), 64'd1);
        drain();

        // Random traffic: mixed modes, chaining, back-pressure and enable gaps.
        bus.in_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!bus.in_valid && $urandom_range(0, 3) != 0) begin
                m = 2'($urandom_range(0, 3));
                drive(m, 1'($urandom), rnd64(), rnd64(), rnd64());
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            ce            = ($urandom_range(0, 9) != 0);
            step();
            if (seen_accept) bus.in_valid = 1'b0;
        end
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
